// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard inputs, buffer controls and performance counters
//               exchanged between the pipeline datapath and pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    // Hazard / event inputs to the controller
    logic [4:0]       id_R1_pos;
    logic [4:0]       id_R2_pos;
    logic             id_use_R1;
    logic             id_use_R2;
    logic [4:0]       ex_dst;
    logic             ex_load;
    logic             ex_redirect;
    logic             wb_halt;
    logic             go;

    // Controls back to the datapath
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_clr;
    logic             idex_en;
    logic             idex_clr;
    logic             exmem_en;
    logic             exmem_clr;
    logic             memwb_en;
    logic             memwb_clr;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Datapath side: supplies hazard info, consumes controls
    modport master (
        output id_R1_pos, id_R2_pos, id_use_R1, id_use_R2,
               ex_dst, ex_load, ex_redirect, wb_halt, go,
        input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
               exmem_en, exmem_clr, memwb_en, memwb_clr,
               halted, cycle_cnt, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_R1_pos, id_R2_pos, id_use_R1, id_use_R2,
               ex_dst, ex_load, ex_redirect, wb_halt, go,
        output pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
               exmem_en, exmem_clr, memwb_en, memwb_clr,
               halted, cycle_cnt, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/flush controller for the 5-stage MIPS pipeline with
//               exit-syscall halt/resume FSM and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire             clk,
    input  wire             rst_n,
    pipe_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALT   = 2'd1,
        S_RESUME = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_freeze;
    logic w_flush;
    logic w_stall;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // r0 is hardwired to zero so it never creates a dependency.
    assign w_lu = bus.ex_load && (bus.ex_dst != 5'd0) &&
                  ((bus.id_use_R1 && (bus.ex_dst == bus.id_R1_pos)) ||
                   (bus.id_use_R2 && (bus.ex_dst == bus.id_R2_pos)));

    // Freeze covers HALT and the RUN cycle in which the syscall reaches WB.
    // RESUME deliberately ignores wb_halt so the syscall can retire.
    assign w_freeze = (r_state == S_HALT) || ((r_state == S_RUN) && bus.wb_halt);
    assign w_flush  = !w_freeze && bus.ex_redirect;
    assign w_stall  = !w_freeze && !bus.ex_redirect && w_lu;

    // Buffer controls, priority freeze > redirect > load-use > normal
    always_comb begin
        bus.pc_en     = 1'b1;
        bus.ifid_en   = 1'b1;
        bus.ifid_clr  = 1'b0;
        bus.idex_en   = 1'b1;
        bus.idex_clr  = 1'b0;
        bus.exmem_en  = 1'b1;
        bus.exmem_clr = 1'b0;
        bus.memwb_en  = 1'b1;
        bus.memwb_clr = 1'b0;
        if (w_freeze) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
        end else if (w_flush) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed
            bus.ifid_clr = 1'b1;
            bus.idex_clr = 1'b1;
        end else if (w_stall) begin
            // Hold PC and IF/ID, send a bubble into EX
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_clr = 1'b1;
        end
    end

    // Halt/resume FSM with registered halted flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.wb_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (bus.go) begin
                        r_state  <= S_RESUME;
                        r_halted <= 1'b0;
                    end
                end
                S_RESUME: begin
                    r_state  <= S_RUN;
                    r_halted <= 1'b0;
                end
                default: begin
                    r_state  <= S_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_stall)           r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush)           r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.halted    = r_halted;
    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the `en`/`clr` pair of every inter-stage buffer (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Detects load-use hazards and taken-branch redirects, and runs a halt/resume state machine for the exit syscall.
- Maintains performance counters (cycles, stalls, flushes) for the board display.

## Interface
Parameters:
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk` in 1: system clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_R1_pos` in 5: rs field of the instruction in ID.
- `id_R2_pos` in 5: rt field of the instruction in ID.
- `id_use_R1` in 1: the ID instruction reads R1.
- `id_use_R2` in 1: the ID instruction reads R2.
- `ex_dst` in 5: destination register of the instruction in EX.
- `ex_load` in 1: the EX instruction is a memory load.
- `ex_redirect` in 1: a branch is taken or a jump is in EX; the PC is loading the target this cycle.
- `wb_halt` in 1: the WB instruction is the exit syscall.
- `go` in 1: resume request (debounced button pulse).
- `pc_en` out 1: PC write enable.
- `ifid_en`, `ifid_clr`, `idex_en`, `idex_clr`, `exmem_en`, `exmem_clr`, `memwb_en`, `memwb_clr` out 1 each: buffer controls. `clr` only takes effect when the matching `en` is 1.
- `halted` out 1: FSM is in HALT.
- `cycle_cnt`, `stall_cnt`, `flush_cnt` out CNT_W each: performance counters.

## Operation
- FSM states: RUN, HALT, RESUME. Encoding is free; only behaviour is specified.
- Load-use hazard:
  - `lu = ex_load & (ex_dst != 0) & ((id_use_R1 & ex_dst == id_R1_pos) | (id_use_R2 & ex_dst == id_R2_pos))`.
- Control outputs are combinational from state and inputs. Priority is freeze > redirect > load-use > normal.
  - Freeze applies when state == HALT, or state == RUN with `wb_halt == 1`. All `en` = 0 and all `clr` = 0.
  - Redirect (`ex_redirect == 1`, not freezing):
    - all `en` = 1;
    - `ifid_clr` = 1 and `idex_clr` = 1;
    - `exmem_clr` = 0 and `memwb_clr` = 0.
    - Any `lu` in the same cycle is ignored, because the ID instruction is wrong-path.
  - Load-use (`lu == 1`, no redirect, not freezing):
    - `pc_en` = 0 and `ifid_en` = 0;
    - `idex_en` = 1 with `idex_clr` = 1, inserting a bubble;
    - EX/MEM and MEM/WB run normally.
  - Normal: all `en` = 1, all `clr` = 0.
- FSM transitions, evaluated at posedge:
  - RUN: `wb_halt` → HALT; otherwise stay in RUN.
  - HALT: `go` → RESUME; otherwise stay in HALT.
  - RESUME → RUN unconditionally.
    - In RESUME, `wb_halt` is ignored, so the syscall leaves WB and is not re-trapped.
    - Redirect and load-use rules still apply in RESUME.
- `go` has no effect in RUN or RESUME.
- `halted` = 1 only in HALT. It is not asserted during the RUN freeze cycle.
- Counters (each wraps modulo 2^CNT_W, no saturation):
  - `cycle_cnt` += 1 every cycle the state is not HALT. This includes the RUN freeze cycle and RESUME.
  - `stall_cnt` += 1 every cycle the load-use rule is the one applied.
  - `flush_cnt` += 1 every cycle the redirect rule is the one applied.

## Timing
- Reset: with `rst_n` = 0 at posedge, the next state is RUN and all counters are 0.
  - Outputs during reset follow the combinational rules for RUN. A registered reset does not force enables low.
  - Reset mid-HALT returns to RUN on the next edge.
- Control latency is zero: outputs react to inputs in the same cycle, with no registered controls.
- Halt:
  - `wb_halt` is seen in cycle N, so cycle N is frozen;
  - HALT holds from cycle N+1 and `halted` = 1 from cycle N+1.
- Resume:
  - `go` is seen in HALT cycle M;
  - cycle M+1 is RESUME, with pipeline advance and the syscall retiring;
  - cycle M+2 is RUN.
- A load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM, so `lu` clears unless a new hazard appears.
- Counter outputs are registered and visible 1 cycle after the counted event.

## Test plan
- **Reset:** `rst_n` = 0 for 2 cycles, then 1 → all counters 0, `halted` = 0. With no hazards, all `en` = 1 and all `clr` = 0. After 10 cycles, `cycle_cnt` = 10.
- **Load-use:**
  - Stimulus: `ex_load` = 1, `ex_dst` = 8, `id_use_R2` = 1, `id_R2_pos` = 8.
  - Response: `pc_en` = `ifid_en` = 0, `idex_clr` = 1, `idex_en` = 1, `exmem_en` = 1; `stall_cnt` goes 0 → 1.
  - Repeat with `ex_dst` = 0: no stall.
- **Redirect:**
  - `ex_redirect` = 1 → `ifid_clr` = `idex_clr` = 1, all `en` = 1, `flush_cnt` + 1.
  - `ex_redirect` together with `lu` → redirect wins; `stall_cnt` unchanged.
- **Halt:**
  - `wb_halt` = 1 in RUN → all `en` = 0 that cycle, `halted` = 1 next cycle.
  - Held 20 cycles with `wb_halt` still 1 → `cycle_cnt` frozen.
- **Resume:**
  - 1-cycle `go` pulse in HALT → next cycle all `en` = 1 despite `wb_halt` = 1, then RUN.
  - `go` asserted in RUN → no effect.
- **Wrap and reset mid-op:**
  - With CNT_W = 4, run 17 cycles → `cycle_cnt` = 1.
  - `rst_n` = 0 during HALT → RUN next cycle, counters 0.
